ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 64-bit RISC-V pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its registered control, operand, immediate, PC and funct outputs. It performs ALU control decode, operand forwarding, ALU evaluation and branch resolution, then captures the results in an internal EX/MEM pipeline register that feeds the memory stage.

## Interface
- XLEN, 64, datapath width.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset: one clock; reset is asynchronous and active-low.
- stall  in  1  hold the EX/MEM register contents.
- flush  in  1  load a bubble (all control outputs 0).
- alu_src, branch, mem_read, reg_write, mem_to_reg, mem_write  in  1 each  control from ID/EX.
- alu_op  in  2  00 add, 01 branch compare, 10 R-type, 11 I-type arithmetic.
- pc_in, read_data1, read_data2, imm_data  in  XLEN  ID/EX operands.
- rs1, rs2, rd_in  in  5  register indices.
- funct  in  4  {funct7[5], funct3}.
- wb_rd  in  5, wb_reg_write  in  1, wb_data  in  XLEN  MEM/WB write-back for forwarding.
- out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg  out  1  registered control.
- alu_result, store_data, branch_target  out  XLEN  registered results.
- out_rd  out  5  registered destination.
- zero  out  1  registered (ALU result == 0).
- branch_taken  out  1  registered; redirect PC to branch_target, flush IF/ID and ID/EX.

## Operation
- ALU decode: alu_op 00 -> ADD. alu_op 01 -> SUB; condition by funct[2:0]: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu; other codes -> not taken.
- alu_op 10 by funct: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND; undefined codes -> ADD.
- alu_op 11: same table, but funct[3] is ignored except when funct[2:0]=101 (SRAI vs SRLI).
- Shift amount = operand B[5:0]. SLT/SLTU produce 0 or 1 zero-extended. Arithmetic wraps modulo 2^XLEN.
- Operand A = fwdA; operand B = imm_data if alu_src else fwdB. store_data = fwdB.
- Forwarding for rs1/rs2 (independently): index 0 never forwarded. Priority 1: out_reg_write=1, out_mem_to_reg=0, out_rd==rs -> alu_result. Priority 2: wb_reg_write=1, wb_rd==rs -> wb_data. Otherwise the register-file value. A load result in EX/MEM is not forwarded; the upstream hazard unit inserts the stall.
- branch_target = pc_in + (imm_data << 1), computed for every instruction.
- Taken = branch & condition true.

## Timing
- Latency one cycle: inputs sampled at edge N appear on outputs after edge N.
- reset low: all outputs to 0 immediately, independent of clk; held while low.
- stall=1, flush=0: every output holds its value. The forwarding source is the held register.
- flush=1: control outputs, branch_taken and zero load 0; data outputs and out_rd load normally. flush wins over stall.
- branch_taken is a single-cycle pulse unless stall holds it.
- Reset asserted mid-operation discards the in-flight instruction; the first post-reset edge loads the inputs normally.

## Configuration
- EX_FORWARDING_EN defined: forwarding muxes as above.
- EX_FORWARDING_EN undefined: fwdA=read_data1, fwdB=read_data2. wb_* ports remain but are unused. Software or the hazard unit must insert NOPs.

## Test plan
- Reset low mid-run with outputs nonzero -> all outputs 0 before the next edge. Release, then ADD 5+7 (alu_op 10, funct 0000) -> alu_result=12, out_reg_write=1.
- Back-to-back dependency: add x3=x1+x2 (10+20), then sub x4=x3-x1 with a stale read_data1 -> second alu_result=20 via EX/MEM forward. Repeat with only wb_rd=3, wb_data=30 -> 20 via MEM/WB. EX/MEM wins when both match.
- rs1=0 with out_rd=0, out_reg_write=1 -> no forward; read_data1 is used.
- BEQ at pc_in=0x100, imm_data=8, operands equal -> branch_taken=1, branch_target=0x110. Unequal -> 0. BLT -1 vs 1 -> taken. BLTU -1 vs 1 -> not taken.
- SRA of 0x8000_0000_0000_0000 by 4 -> 0xF800_0000_0000_0000. SRAI (alu_op 11, funct 1101) gives the same result. SRLI -> 0x0800_0000_0000_0000.
- stall=1 for 3 cycles with changing inputs -> outputs frozen. Then stall=1 and flush=1 together -> control outputs 0 and alu_result updated.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the 64-bit RISC-V pipeline: ALU decode, operand forwarding, ALU, branch resolution, EX/MEM register.
// Optional feature macro: EX_FORWARDING_EN (EX/MEM and MEM/WB forwarding muxes; undefined -> register-file operands only).
module ex_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            alu_src,
    input  logic            branch,
    input  logic            mem_read,
    input  logic            reg_write,
    input  logic            mem_to_reg,
    input  logic            mem_write,
    input  logic [1:0]      alu_op,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] read_data2,
    input  logic [XLEN-1:0] imm_data,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd_in,
    input  logic [3:0]      funct,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_reg_write,
    output logic            out_mem_to_reg,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] branch_target,
    output logic [4:0]      out_rd,
    output logic            zero,
    output logic            branch_taken
);

    typedef enum logic [3:0] {
        FN_ADD, FN_SUB, FN_SLL, FN_SLT, FN_SLTU,
        FN_XOR, FN_SRL, FN_SRA, FN_OR, FN_AND
    } alu_fn_e;

    logic            mem_read_q, mem_write_q, reg_write_q, mem_to_reg_q, zero_q, taken_q;
    logic [XLEN-1:0] alu_result_q, store_data_q, branch_target_q;
    logic [4:0]      rd_q;

    logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_d, target_d;
    logic [5:0]      shamt;
    logic [3:0]      fsel;
    alu_fn_e         fn;
    logic            cond, taken_d, zero_d;

`ifdef EX_FORWARDING_EN
    // A load in EX/MEM has no data yet, so only non-load producers forward from there.
    always_comb begin
        fwd_a = read_data1;
        if (rs1 != 5'd0 && reg_write_q && !mem_to_reg_q && rd_q == rs1)
            fwd_a = alu_result_q;
        else if (rs1 != 5'd0 && wb_reg_write && wb_rd == rs1)
            fwd_a = wb_data;
    end

    always_comb begin
        fwd_b = read_data2;
        if (rs2 != 5'd0 && reg_write_q && !mem_to_reg_q && rd_q == rs2)
            fwd_b = alu_result_q;
        else if (rs2 != 5'd0 && wb_reg_write && wb_rd == rs2)
            fwd_b = wb_data;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{wb_rd, wb_reg_write, wb_data, rs1, rs2};
    assign fwd_a = read_data1;
    assign fwd_b = read_data2;
`endif

    assign op_b  = alu_src ? imm_data : fwd_b;
    assign shamt = op_b[5:0];

    // I-type: funct7[5] only distinguishes SRAI from SRLI.
    always_comb begin
        fsel = funct;
        if (alu_op == 2'b11 && funct[2:0] != 3'b101)
            fsel[3] = 1'b0;
        fn = FN_ADD;
        case (alu_op)
            2'b00: fn = FN_ADD;
            2'b01: fn = FN_SUB;
            default: begin
                case (fsel)
                    4'b0000: fn = FN_ADD;
                    4'b1000: fn = FN_SUB;
                    4'b0001: fn = FN_SLL;
                    4'b0010: fn = FN_SLT;
                    4'b0011: fn = FN_SLTU;
                    4'b0100: fn = FN_XOR;
                    4'b0101: fn = FN_SRL;
                    4'b1101: fn = FN_SRA;
                    4'b0110: fn = FN_OR;
                    4'b0111: fn = FN_AND;
                    default: fn = FN_ADD;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_d = fwd_a + op_b;
        case (fn)
            FN_ADD:  alu_d = fwd_a + op_b;
            FN_SUB:  alu_d = fwd_a - op_b;
            FN_SLL:  alu_d = fwd_a << shamt;
            FN_SLT:  alu_d = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
            FN_SLTU: alu_d = {{(XLEN-1){1'b0}}, fwd_a < op_b};
            FN_XOR:  alu_d = fwd_a ^ op_b;
            FN_SRL:  alu_d = fwd_a >> shamt;
            FN_SRA:  alu_d = $unsigned($signed(fwd_a) >>> shamt);
            FN_OR:   alu_d = fwd_a | op_b;
            FN_AND:  alu_d = fwd_a & op_b;
            default: alu_d = fwd_a + op_b;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (funct[2:0])
            3'b000:  cond = (fwd_a == fwd_b);
            3'b001:  cond = (fwd_a != fwd_b);
            3'b100:  cond = ($signed(fwd_a) <  $signed(fwd_b));
            3'b101:  cond = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  cond = (fwd_a <  fwd_b);
            3'b111:  cond = (fwd_a >= fwd_b);
            default: cond = 1'b0;
        endcase
    end

    assign taken_d  = branch & cond;
    assign zero_d   = (alu_d == '0);
    assign target_d = pc_in + (imm_data << 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            reg_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            zero_q          <= 1'b0;
            taken_q         <= 1'b0;
            alu_result_q    <= '0;
            store_data_q    <= '0;
            branch_target_q <= '0;
            rd_q            <= 5'd0;
        end else if (flush || !stall) begin
            // A flush still loads the datapath; only the control side becomes a bubble.
            mem_read_q      <= flush ? 1'b0 : mem_read;
            mem_write_q     <= flush ? 1'b0 : mem_write;
            reg_write_q     <= flush ? 1'b0 : reg_write;
            mem_to_reg_q    <= flush ? 1'b0 : mem_to_reg;
            zero_q          <= flush ? 1'b0 : zero_d;
            taken_q         <= flush ? 1'b0 : taken_d;
            alu_result_q    <= alu_d;
            store_data_q    <= fwd_b;
            branch_target_q <= target_d;
            rd_q            <= rd_in;
        end
    end

    assign out_mem_read   = mem_read_q;
    assign out_mem_write  = mem_write_q;
    assign out_reg_write  = reg_write_q;
    assign out_mem_to_reg = mem_to_reg_q;
    assign zero           = zero_q;
    assign branch_taken   = taken_q;
    assign alu_result     = alu_result_q;
    assign store_data     = store_data_q;
    assign branch_target  = branch_target_q;
    assign out_rd         = rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: scoreboard of expected EX/MEM contents plus spot checks on known answers.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        alu_src, branch, mem_read, reg_write, mem_to_reg, mem_write;
    logic [1:0]  alu_op;
    logic [63:0] pc_in, read_data1, read_data2, imm_data, wb_data;
    logic [4:0]  rs1, rs2, rd_in, wb_rd;
    logic [3:0]  funct;
    logic        wb_reg_write;
    logic        out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg, zero, branch_taken;
    logic [63:0] alu_result, store_data, branch_target;
    logic [4:0]  out_rd;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        mr, mw, rw, m2r, z, tk;
        logic [63:0] res, sd, bt;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    exp_t prev;

    ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .alu_src(alu_src), .branch(branch), .mem_read(mem_read), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_op(alu_op),
        .pc_in(pc_in), .read_data1(read_data1), .read_data2(read_data2), .imm_data(imm_data),
        .rs1(rs1), .rs2(rs2), .rd_in(rd_in), .funct(funct),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
        .alu_result(alu_result), .store_data(store_data), .branch_target(branch_target),
        .out_rd(out_rd), .zero(zero), .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic logic [63:0] m_alu(input logic [1:0] op, input logic [3:0] f,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [3:0] g;
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        g = f;
        if (op == 2'b11 && f[2:0] != 3'b101) g[3] = 1'b0;
        case (g)
            4'b1000: return a - b;
            4'b0001: return a << b[5:0];
            4'b0010: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'b0011: return (a < b) ? 64'd1 : 64'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> b[5:0];
            4'b1101: return $unsigned($signed(a) >>> b[5:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic m_cond(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic ins(input logic [1:0] op, input logic [3:0] fn, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [63:0] va, input logic [63:0] vb,
                       input logic [63:0] im, input logic src, input logic br);
        alu_op = op; funct = fn; rs1 = a; rs2 = b; rd_in = d;
        read_data1 = va; read_data2 = vb; imm_data = im; alu_src = src;
        branch = br; reg_write = !br; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
    endtask

    // Predict the EX/MEM contents for the current inputs, clock once, then compare.
    task automatic go(input logic st, input logic fl);
        exp_t n, e;
        logic [63:0] fa, fb, b;
        stall = st; flush = fl;
        fa = read_data1; fb = read_data2;
`ifdef EX_FORWARDING_EN
        if (rs1 != 0 && prev.rw && !prev.m2r && prev.rd == rs1) fa = prev.res;
        else if (rs1 != 0 && wb_reg_write && wb_rd == rs1) fa = wb_data;
        if (rs2 != 0 && prev.rw && !prev.m2r && prev.rd == rs2) fb = prev.res;
        else if (rs2 != 0 && wb_reg_write && wb_rd == rs2) fb = wb_data;
`endif
        b = alu_src ? imm_data : fb;
        n.res = m_alu(alu_op, funct, fa, b);
        n.sd  = fb;
        n.bt  = pc_in + (imm_data << 1);
        n.rd  = rd_in;
        n.z   = (n.res == 64'd0);
        n.tk  = branch & m_cond(funct[2:0], fa, fb);
        n.mr = mem_read; n.mw = mem_write; n.rw = reg_write; n.m2r = mem_to_reg;
        if (fl) begin
            n.mr = 0; n.mw = 0; n.rw = 0; n.m2r = 0; n.z = 0; n.tk = 0;
        end else if (st) begin
            n = prev;
        end
        sb.push_back(n);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("sb.alu_result", alu_result, e.res);
        chk("sb.store_data", store_data, e.sd);
        chk("sb.branch_target", branch_target, e.bt);
        chk("sb.out_rd", {59'd0, out_rd}, {59'd0, e.rd});
        chk("sb.ctrl", {58'd0, out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg, zero, branch_taken},
            {58'd0, e.mr, e.mw, e.rw, e.m2r, e.z, e.tk});
        prev = e;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {alu_result | store_data | branch_target},  64'd0);
        chk(tag, {58'd0, out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg, zero, branch_taken}
                 | {59'd0, out_rd}, 64'd0);
    endtask

    initial begin
        reset = 1'b0; stall = 0; flush = 0; pc_in = 0;
        wb_rd = 0; wb_reg_write = 0; wb_data = 0;
        ins(2'b10, 4'b0000, 5'd1, 5'd2, 5'd3, 64'd9, 64'd9, 64'd0, 1'b0, 1'b0);
        prev = '{default: '0};
        #1 chk_all_zero("reset_initial");
        @(posedge clk); #1 chk_all_zero("reset_held");
        reset = 1'b1;

        // ADD 5+7
        ins(2'b10, 4'b0000, 5'd5, 5'd6, 5'd7, 64'd5, 64'd7, 64'd0, 1'b0, 1'b0);
        go(0, 0);
        chk("add12", alu_result, 64'd12);
        chk("add12_rw", {63'd0, out_reg_write}, 64'd1);

        // asynchronous reset mid-cycle with nonzero outputs
        #2 reset = 1'b0;
        #1 chk_all_zero("reset_async");
        @(posedge clk); #1 chk_all_zero("reset_async_held");
        reset = 1'b1;
        prev = '{default: '0};
        go(0, 0);
        chk("add12_post_reset", alu_result, 64'd12);

        // EX/MEM forward
        ins(2'b10, 4'b0000, 5'd1, 5'd2, 5'd3, 64'd10, 64'd20, 64'd0, 1'b0, 1'b0); go(0, 0);
        chk("add30", alu_result, 64'd30);
        ins(2'b10, 4'b1000, 5'd3, 5'd1, 5'd4, 64'd0, 64'd10, 64'd0, 1'b0, 1'b0); go(0, 0);
`ifdef EX_FORWARDING_EN
        chk("fwd_exmem", alu_result, 64'd20);
`else
        chk("nofwd_exmem", alu_result, 64'hFFFF_FFFF_FFFF_FFF6);
`endif
        // MEM/WB forward
        ins(2'b10, 4'b0000, 5'd7, 5'd8, 5'd9, 64'd1, 64'd1, 64'd0, 1'b0, 1'b0); go(0, 0);
        wb_reg_write = 1; wb_rd = 5'd3; wb_data = 64'd30;
        ins(2'b10, 4'b1000, 5'd3, 5'd1, 5'd4, 64'd0, 64'd10, 64'd0, 1'b0, 1'b0); go(0, 0);
`ifdef EX_FORWARDING_EN
        chk("fwd_memwb", alu_result, 64'd20);
`else
        chk("nofwd_memwb", alu_result, 64'hFFFF_FFFF_FFFF_FFF6);
`endif
        // both match: EX/MEM wins
        ins(2'b10, 4'b0000, 5'd1, 5'd2, 5'd3, 64'd100, 64'd5, 64'd0, 1'b0, 1'b0); go(0, 0);
        ins(2'b10, 4'b1000, 5'd3, 5'd1, 5'd4, 64'd0, 64'd10, 64'd0, 1'b0, 1'b0); go(0, 0);
`ifdef EX_FORWARDING_EN
        chk("fwd_priority", alu_result, 64'd95);
`endif
        wb_reg_write = 0;

        // x0 is never forwarded
        ins(2'b10, 4'b0000, 5'd5, 5'd6, 5'd0, 64'd3, 64'd4, 64'd0, 1'b0, 1'b0); go(0, 0);
        wb_reg_write = 1; wb_rd = 5'd0; wb_data = 64'd99;
        ins(2'b10, 4'b0000, 5'd0, 5'd6, 5'd8, 64'h55, 64'd1, 64'd0, 1'b0, 1'b0); go(0, 0);
        chk("x0_nofwd", alu_result, 64'h56);
        wb_reg_write = 0;

        // branches
        pc_in = 64'h100;
        ins(2'b01, 4'b0000, 5'd10, 5'd11, 5'd0, 64'd42, 64'd42, 64'd8, 1'b0, 1'b1); go(0, 0);
        chk("beq_taken", {63'd0, branch_taken}, 64'd1);
        chk("beq_target", branch_target, 64'h110);
        ins(2'b01, 4'b0000, 5'd10, 5'd11, 5'd0, 64'd42, 64'd43, 64'd8, 1'b0, 1'b1); go(0, 0);
        chk("beq_not_taken", {63'd0, branch_taken}, 64'd0);
        ins(2'b01, 4'b0100, 5'd10, 5'd11, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd8, 1'b0, 1'b1); go(0, 0);
        chk("blt_taken", {63'd0, branch_taken}, 64'd1);
        ins(2'b01, 4'b0110, 5'd10, 5'd11, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd8, 1'b0, 1'b1); go(0, 0);
        chk("bltu_not_taken", {63'd0, branch_taken}, 64'd0);
        pc_in = 0;

        // shifts
        ins(2'b10, 4'b1101, 5'd12, 5'd13, 5'd14, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 1'b0, 1'b0); go(0, 0);
        chk("sra", alu_result, 64'hF800_0000_0000_0000);
        ins(2'b11, 4'b1101, 5'd12, 5'd13, 5'd15, 64'h8000_0000_0000_0000, 64'd0, 64'd4, 1'b1, 1'b0); go(0, 0);
        chk("srai", alu_result, 64'hF800_0000_0000_0000);
        ins(2'b11, 4'b0101, 5'd12, 5'd13, 5'd16, 64'h8000_0000_0000_0000, 64'd0, 64'd4, 1'b1, 1'b0); go(0, 0);
        chk("srli", alu_result, 64'h0800_0000_0000_0000);

        // I-type ignores funct[3] outside shifts; wrap and zero flag; undefined R funct -> ADD
        ins(2'b11, 4'b1000, 5'd17, 5'd18, 5'd19, 64'd10, 64'd0, 64'd5, 1'b1, 1'b0); go(0, 0);
        chk("addi_f3", alu_result, 64'd15);
        ins(2'b10, 4'b0000, 5'd17, 5'd18, 5'd19, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b0); go(0, 0);
        chk("add_wrap", alu_result, 64'd0);
        chk("zero_flag", {63'd0, zero}, 64'd1);
        ins(2'b10, 4'b1001, 5'd17, 5'd18, 5'd19, 64'd6, 64'd7, 64'd0, 1'b0, 1'b0); go(0, 0);
        chk("undef_add", alu_result, 64'd13);
        ins(2'b10, 4'b0010, 5'd17, 5'd18, 5'd19, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'd0, 1'b0, 1'b0); go(0, 0);
        chk("slt", alu_result, 64'd1);

        // store: store_data carries rs2 value
        ins(2'b00, 4'b0011, 5'd20, 5'd21, 5'd0, 64'h1000, 64'hABCD, 64'h10, 1'b1, 1'b0);
        reg_write = 0; mem_write = 1; go(0, 0);
        chk("store_addr", alu_result, 64'h1010);
        chk("store_data", store_data, 64'hABCD);

        // stall holds for 3 cycles with changing inputs
        ins(2'b10, 4'b0110, 5'd20, 5'd21, 5'd22, 64'hF0, 64'h0F, 64'd0, 1'b0, 1'b0); go(0, 0);
        for (int i = 0; i < 3; i++) begin
            ins(2'b10, 4'b0000, 5'd23, 5'd24, 5'd25, 64'(i * 100 + 1), 64'd2, 64'd0, 1'b0, 1'b0);
            go(1, 0);
            chk("stall_hold", alu_result, 64'hFF);
        end
        // stall and flush together: flush wins
        ins(2'b10, 4'b0000, 5'd23, 5'd24, 5'd25, 64'd40, 64'd2, 64'd0, 1'b0, 1'b0); go(1, 1);
        chk("flush_rw", {63'd0, out_reg_write}, 64'd0);
        chk("flush_res", alu_result, 64'd42);

        // flush squashes a taken branch but updates the target
        pc_in = 64'h200;
        ins(2'b01, 4'b0000, 5'd10, 5'd11, 5'd0, 64'd1, 64'd1, 64'h20, 1'b0, 1'b1); go(0, 1);
        chk("flush_taken", {63'd0, branch_taken}, 64'd0);
        chk("flush_target", branch_target, 64'h240);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
